// File: rtl/mdu_pkg.sv
// Shared types and constants for the iterative multiply/divide unit.
package mdu_pkg;

    localparam int unsigned DEF_DATA_W = 8;

    localparam logic OP_MUL = 1'b0;
    localparam logic OP_DIV = 1'b1;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_MUL  = 2'd1,
        ST_DIV  = 2'd2,
        ST_DONE = 2'd3
    } state_t;

endpackage

// File: rtl/mdu_iter_step.sv
// One combinational iteration: shift-add multiply step or restoring divide step.
module mdu_iter_step
    import mdu_pkg::*;
#(
    parameter int unsigned DATA_W = DEF_DATA_W
) (
    input  logic                  is_div,
    input  logic [2*DATA_W-1:0]   acc,
    input  logic [DATA_W-1:0]     operand,
    output logic [2*DATA_W-1:0]   acc_next_c
);

    logic [DATA_W:0]   sum;
    logic [DATA_W:0]   rem_shift;
    logic [DATA_W-1:0] diff;
    logic              fits;

    // Multiply keeps the multiplier in the low half; divide keeps the partial remainder in the high half.
    always_comb begin
        sum        = {1'b0, acc[2*DATA_W-1:DATA_W]} + {1'b0, operand};
        rem_shift  = {acc[2*DATA_W-1:DATA_W], acc[DATA_W-1]};
        diff       = rem_shift[DATA_W-1:0] - operand;
        fits       = (rem_shift >= {1'b0, operand});
        acc_next_c = '0;
        if (is_div) begin
            if (fits) begin
                acc_next_c = {diff, acc[DATA_W-2:0], 1'b1};
            end else begin
                acc_next_c = {rem_shift[DATA_W-1:0], acc[DATA_W-2:0], 1'b0};
            end
        end else begin
            if (acc[0]) begin
                acc_next_c = {sum, acc[DATA_W-1:1]};
            end else begin
                acc_next_c = {1'b0, acc[2*DATA_W-1:1]};
            end
        end
    end

endmodule

// File: rtl/mult_div_unit.sv
// Iterative unsigned multiply/divide unit with HI/LO result registers.
module mult_div_unit
    import mdu_pkg::*;
#(
    parameter int unsigned DATA_W = DEF_DATA_W
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              start,
    input  logic              op,
    input  logic [DATA_W-1:0] src_a,
    input  logic [DATA_W-1:0] src_b,
    input  logic              hi_we,
    input  logic              lo_we,
    input  logic [DATA_W-1:0] wr_data,
    output logic              busy,
    output logic              done,
    output logic              div_by_zero,
    output logic [DATA_W-1:0] hi,
    output logic [DATA_W-1:0] lo
);

    localparam int unsigned CNT_W = $clog2(DATA_W) + 1;

    state_t              state;
    state_t              state_next;
    logic [CNT_W-1:0]    cnt;
    logic [DATA_W-1:0]   op_a;
    logic [DATA_W-1:0]   op_b;
    logic [2*DATA_W-1:0] acc;
    logic [2*DATA_W-1:0] acc_step;

    logic accept;
    logic step_en;
    logic finish;
    logic wr_ok;
    logic busy_d;
    logic done_d;

    mdu_iter_step #(.DATA_W(DATA_W)) u_step (
        .is_div     (state == ST_DIV),
        .acc        (acc),
        .operand    ((state == ST_DIV) ? op_b : op_a),
        .acc_next_c (acc_step)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= ST_IDLE;
        end else begin
            state <= state_next;
        end
    end

    // Control decode: next state plus datapath enables.
    always_comb begin
        state_next = state;
        accept     = 1'b0;
        step_en    = 1'b0;
        finish     = 1'b0;
        wr_ok      = 1'b0;
        case (state)
            ST_IDLE, ST_DONE: begin
                wr_ok = 1'b1;
                if (start) begin
                    accept     = 1'b1;
                    state_next = (op == OP_DIV) ? ST_DIV : ST_MUL;
                end else begin
                    state_next = ST_IDLE;
                end
            end
            ST_MUL, ST_DIV: begin
                if (cnt == CNT_W'(DATA_W)) begin
                    finish     = 1'b1;
                    state_next = ST_DONE;
                end else begin
                    step_en = 1'b1;
                end
            end
            default: state_next = ST_IDLE;
        endcase
        busy_d = ((state_next == ST_MUL) || (state_next == ST_DIV)) &&
                 ((state == ST_MUL) || (state == ST_DIV));
        done_d = (state_next == ST_DONE);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt         <= '0;
            op_a        <= '0;
            op_b        <= '0;
            acc         <= '0;
            hi          <= '0;
            lo          <= '0;
            busy        <= 1'b0;
            done        <= 1'b0;
            div_by_zero <= 1'b0;
        end else begin
            busy <= busy_d;
            done <= done_d;
            if (wr_ok && hi_we) begin
                hi <= wr_data;
            end
            if (wr_ok && lo_we) begin
                lo <= wr_data;
            end
            if (accept) begin
                op_a        <= src_a;
                op_b        <= src_b;
                cnt         <= '0;
                div_by_zero <= 1'b0;
                acc         <= {{DATA_W{1'b0}}, (op == OP_DIV) ? src_a : src_b};
            end
            if (step_en) begin
                acc <= acc_step;
                cnt <= cnt + CNT_W'(1);
            end
            if (finish) begin
                hi <= acc[2*DATA_W-1:DATA_W];
                lo <= acc[DATA_W-1:0];
                if (state == ST_DIV) begin
                    div_by_zero <= (op_b == '0);
                end
            end
        end
    end

endmodule

// File: tb/tb_mult_div_unit.sv
// Directed self-checking bench for mult_div_unit.
module tb_mult_div_unit;

    logic       clk;
    logic       rst_n;
    logic       start;
    logic       op;
    logic [7:0] src_a;
    logic [7:0] src_b;
    logic       hi_we;
    logic       lo_we;
    logic [7:0] wr_data;
    logic       busy;
    logic       done;
    logic       div_by_zero;
    logic [7:0] hi;
    logic [7:0] lo;

    int checks   = 0;
    int failures = 0;

    mult_div_unit #(.DATA_W(8)) dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .start       (start),
        .op          (op),
        .src_a       (src_a),
        .src_b       (src_b),
        .hi_we       (hi_we),
        .lo_we       (lo_we),
        .wr_data     (wr_data),
        .busy        (busy),
        .done        (done),
        .div_by_zero (div_by_zero),
        .hi          (hi),
        .lo          (lo)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s got=%0h exp=%0h at %0t", tag, got, exp, $time);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Issue one operation and follow it to the done pulse, checking cycle-exact timing.
    task automatic do_op(input logic o, input logic [7:0] a, input logic [7:0] b,
                         input logic [7:0] prev_hi, input logic [7:0] prev_lo, input bit inject);
        start = 1'b1;
        op    = o;
        src_a = a;
        src_b = b;
        tick();
        start = 1'b0;
        check_eq("busy_at_accept", 32'(busy), 32'd0);
        check_eq("dbz_cleared", 32'(div_by_zero), 32'd0);
        check_eq("done_at_accept", 32'(done), 32'd0);
        for (int i = 1; i <= 8; i++) begin
            if (inject && i == 3) begin
                start   = 1'b1;
                op      = ~o;
                src_a   = 8'h01;
                src_b   = 8'h01;
                hi_we   = 1'b1;
                wr_data = 8'hAA;
            end
            tick();
            start = 1'b0;
            hi_we = 1'b0;
            check_eq("busy_iter", 32'(busy), 32'd1);
            check_eq("done_iter", 32'(done), 32'd0);
            check_eq("hi_stable", 32'(hi), 32'(prev_hi));
            check_eq("lo_stable", 32'(lo), 32'(prev_lo));
        end
        tick();
        check_eq("done_pulse", 32'(done), 32'd1);
        check_eq("busy_fall", 32'(busy), 32'd0);
    endtask

    initial begin
        rst_n   = 1'b1;
        start   = 1'b0;
        op      = 1'b0;
        src_a   = '0;
        src_b   = '0;
        hi_we   = 1'b0;
        lo_we   = 1'b0;
        wr_data = '0;
        #1 rst_n = 1'b0;
        tick();
        tick();
        check_eq("rst_busy", 32'(busy), 32'd0);
        check_eq("rst_done", 32'(done), 32'd0);
        check_eq("rst_dbz", 32'(div_by_zero), 32'd0);
        check_eq("rst_hi", 32'(hi), 32'd0);
        check_eq("rst_lo", 32'(lo), 32'd0);
        rst_n = 1'b1;

        // 13 x 11
        do_op(1'b0, 8'd13, 8'd11, 8'h00, 8'h00, 1'b0);
        check_eq("mul13x11_hi", 32'(hi), 32'h00);
        check_eq("mul13x11_lo", 32'(lo), 32'h8F);
        tick();
        check_eq("done_once", 32'(done), 32'd0);

        // 255 x 255 then back-to-back 200 / 7
        do_op(1'b0, 8'd255, 8'd255, 8'h00, 8'h8F, 1'b0);
        check_eq("mul255_hi", 32'(hi), 32'hFE);
        check_eq("mul255_lo", 32'(lo), 32'h01);
        do_op(1'b1, 8'd200, 8'd7, 8'hFE, 8'h01, 1'b0);
        check_eq("div200_7_lo", 32'(lo), 32'h1C);
        check_eq("div200_7_hi", 32'(hi), 32'h04);
        check_eq("div200_7_dbz", 32'(div_by_zero), 32'd0);
        tick();

        // 50 / 0 then 2 x 3 clears the flag
        do_op(1'b1, 8'd50, 8'd0, 8'h04, 8'h1C, 1'b0);
        check_eq("div0_lo", 32'(lo), 32'hFF);
        check_eq("div0_hi", 32'(hi), 32'h32);
        check_eq("div0_flag", 32'(div_by_zero), 32'd1);
        tick();
        check_eq("div0_flag_sticky", 32'(div_by_zero), 32'd1);
        do_op(1'b0, 8'd2, 8'd3, 8'h32, 8'hFF, 1'b0);
        check_eq("mul2x3_lo", 32'(lo), 32'h06);
        check_eq("mul2x3_hi", 32'(hi), 32'h00);
        tick();

        // 6 x 7 with ignored start and mthi mid-iteration
        do_op(1'b0, 8'd6, 8'd7, 8'h00, 8'h06, 1'b1);
        check_eq("mul6x7_hi", 32'(hi), 32'h00);
        check_eq("mul6x7_lo", 32'(lo), 32'h2A);
        tick();
        check_eq("no_requeue_busy", 32'(busy), 32'd0);
        check_eq("no_requeue_done", 32'(done), 32'd0);

        // mtlo / mthi in IDLE
        lo_we   = 1'b1;
        wr_data = 8'h5C;
        tick();
        lo_we = 1'b0;
        check_eq("mtlo", 32'(lo), 32'h5C);
        hi_we   = 1'b1;
        wr_data = 8'h11;
        tick();
        hi_we = 1'b0;
        check_eq("mthi", 32'(hi), 32'h11);
        check_eq("mthi_lo_kept", 32'(lo), 32'h5C);

        // async reset mid 9 x 9
        start = 1'b1;
        op    = 1'b0;
        src_a = 8'd9;
        src_b = 8'd9;
        tick();
        start = 1'b0;
        repeat (4) tick();
        check_eq("pre_rst_busy", 32'(busy), 32'd1);
        #1 rst_n = 1'b0;
        #1;
        check_eq("arst_busy", 32'(busy), 32'd0);
        check_eq("arst_done", 32'(done), 32'd0);
        check_eq("arst_hi", 32'(hi), 32'd0);
        check_eq("arst_lo", 32'(lo), 32'd0);
        tick();
        tick();
        rst_n = 1'b1;
        for (int i = 0; i < 12; i++) begin
            tick();
            check_eq("no_done_after_rst", 32'(done), 32'd0);
        end
        do_op(1'b0, 8'd9, 8'd9, 8'h00, 8'h00, 1'b0);
        check_eq("mul9x9_lo", 32'(lo), 32'h51);
        check_eq("mul9x9_hi", 32'(hi), 32'h00);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
